// File: rtl/data_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_bus_responder
//  Purpose  : Responder end of the CPU data-memory bus. Accepts one load or
//             store at a time, decodes it against the memory map, drives the
//             synchronous data RAM or the instruction ROM's second read port,
//             and returns a response carrying read data or an error flag.
//  Ports    :
//    clk, rst_n            clock, synchronous active-low reset
//    req_valid/req_ready   request handshake (req_ready is registered)
//    req_we, req_addr      1 = store / 0 = load, byte address
//    req_wdata, req_be     store data and byte enables
//    rsp_valid/rsp_ready   response handshake
//    rsp_rdata, rsp_err    load data (0 on store or error), access fault
//    ram_*                 data RAM port (1-cycle read latency)
//    rom_*                 instruction ROM read port (1-cycle read latency)
//    err_count             saturating count of error responses
//  Revision : 1.0  initial release
// ============================================================================
module data_bus_responder #(
    parameter logic [31:0] DATA_RAM_BEGIN = 32'h0000_4000,
    parameter logic [31:0] DATA_RAM_END   = 32'h0000_6000,
    parameter logic [31:0] INST_ROM_BEGIN = 32'h0000_2000,
    parameter logic [31:0] INST_ROM_END   = 32'h0000_4000,
    parameter int          WORD_WIDTH     = 32,
    parameter int          ADDR_WIDTH     = 11,
    parameter int          ROM_ADDR_WIDTH = 11
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [31:0]               req_addr,
    input  logic [WORD_WIDTH-1:0]     req_wdata,
    input  logic [3:0]                req_be,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WORD_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic                      ram_en,
    output logic                      ram_we,
    output logic [ADDR_WIDTH-1:0]     ram_addr,
    output logic [WORD_WIDTH-1:0]     ram_wdata,
    output logic [3:0]                ram_be,
    input  logic [WORD_WIDTH-1:0]     ram_rdata,
    output logic                      rom_en,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [WORD_WIDTH-1:0]     rom_rdata,
    output logic [7:0]                err_count
);

    localparam logic [7:0] C_ERR_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_req_ready;
    logic [WORD_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rd_rom;
    logic [7:0]            r_err_count;

    logic                  w_ram_hit;
    logic                  w_rom_hit;
    logic                  w_err;
    logic                  w_accept;
    logic [31:0]           w_ram_off;
    logic [31:0]           w_rom_off;

    // Address decode; both window ends are exclusive.
    assign w_ram_hit = (req_addr >= DATA_RAM_BEGIN) && (req_addr < DATA_RAM_END);
    assign w_rom_hit = (req_addr >= INST_ROM_BEGIN) && (req_addr < INST_ROM_END);
    assign w_err     = (req_addr[1:0] != 2'b00)
                     || !(w_ram_hit || w_rom_hit)
                     || (req_we && w_rom_hit)
                     || (req_we && (req_be == 4'b0000));

    // req_ready is only ever high in IDLE; gating with rst_n keeps the memory
    // strobes quiet on an edge where reset is being applied.
    assign w_accept  = req_valid && r_req_ready && rst_n;

    assign w_ram_off = req_addr - DATA_RAM_BEGIN;
    assign w_rom_off = req_addr - INST_ROM_BEGIN;

    // Memory strobes exist only in the accept cycle of a valid access.
    assign ram_en    = w_accept && !w_err && w_ram_hit;
    assign ram_we    = ram_en && req_we;
    assign ram_addr  = ADDR_WIDTH'(w_ram_off >> 2);
    assign ram_wdata = req_wdata;
    assign ram_be    = req_be;
    assign rom_en    = w_accept && !w_err && w_rom_hit && !req_we;
    assign rom_addr  = ROM_ADDR_WIDTH'(w_rom_off >> 2);

    assign req_ready = r_req_ready;
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign err_count = r_err_count;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    // Stores and faults answer immediately; loads wait for
                    // the memory's one-cycle read latency.
                    w_next = (w_err || req_we) ? RESP : RD_WAIT;
                end
            end
            RD_WAIT: w_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rd_rom    <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_state     <= w_next;
            // Registered ready: high exactly while the FSM sits in IDLE.
            r_req_ready <= (w_next == IDLE);
            if (w_accept) begin
                r_rsp_rdata <= '0;
                r_rsp_err   <= w_err;
                r_rd_rom    <= w_rom_hit;
                if (w_err && (r_err_count != C_ERR_MAX)) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
            if (r_state == RD_WAIT) begin
                r_rsp_rdata <= r_rd_rom ? rom_rdata : ram_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_bus_responder
//  Purpose  : Self-checking bench for data_bus_responder. Provides RAM and ROM
//             macro models, a transaction-level reference model and a
//             per-cycle compare process, plus directed literal checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_be = 4'h0;
    logic        rsp_ready = 1'b1;
    logic        req_ready, rsp_valid, rsp_err, ram_en, ram_we, rom_en;
    logic [31:0] rsp_rdata, ram_wdata, rom_rdata_w, ram_rdata_w;
    logic [10:0] ram_addr, rom_addr;
    logic [3:0]  ram_be;
    logic [7:0]  err_count;
    logic [31:0] ram_rdata = 32'h0;
    logic [31:0] rom_rdata = 32'h0;

    assign ram_rdata_w = ram_rdata;
    assign rom_rdata_w = rom_rdata;

    data_bus_responder dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_rdata(ram_rdata_w),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata_w),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- spec-level helpers ----------------
    function automatic bit in_ram(logic [31:0] a);
        return (a >= 32'h4000) && (a < 32'h6000);
    endfunction
    function automatic bit in_rom(logic [31:0] a);
        return (a >= 32'h2000) && (a < 32'h4000);
    endfunction
    function automatic bit spec_err(bit we, logic [31:0] a, logic [3:0] be);
        return (a % 4 != 0) || !(in_ram(a) || in_rom(a)) || (we && in_rom(a)) || (we && be == 4'h0);
    endfunction
    function automatic logic [31:0] ram_init(int idx);
        return 32'hA5A5_0000 | 32'(idx);
    endfunction
    function automatic logic [31:0] rom_word(int idx);
        return 32'h1234_0000 | 32'(idx);
    endfunction
    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] be);
        logic [31:0] r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // ---------------- memory macro models (driven by DUT strobes) ----------------
    logic [31:0] bram [int];
    function automatic logic [31:0] bram_rd(int i);
        return bram.exists(i) ? bram[i] : ram_init(i);
    endfunction
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= bram_rd(int'(ram_addr));
            if (ram_we) bram[int'(ram_addr)] = merge(bram_rd(int'(ram_addr)), ram_wdata, ram_be);
        end
        if (rom_en) rom_rdata <= rom_word(int'(rom_addr));
    end

    // ---------------- rsp_ready driver ----------------
    bit rand_rdy  = 1'b0;
    bit rdy_force = 1'b1;
    always @(posedge clk) begin
        #2;
        rsp_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    // ---------------- transaction-level reference model ----------------
    logic [31:0] mmem [int];
    function automatic logic [31:0] mmem_rd(int i);
        return mmem.exists(i) ? mmem[i] : ram_init(i);
    endfunction
    bit          m_ready = 1'b0;
    bit          m_valid = 1'b0;
    int          m_wait  = 0;
    int          m_cnt   = 0;
    logic [31:0] m_rdata = 32'h0;
    bit          m_err   = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ready = 1'b0; m_valid = 1'b0; m_wait = 0; m_cnt = 0;
        end else if (m_ready && req_valid) begin
            m_ready = 1'b0;
            m_err   = spec_err(req_we, req_addr, req_be);
            m_rdata = 32'h0;
            if (m_err) begin
                if (m_cnt < 255) m_cnt++;
                m_valid = 1'b1;
            end else if (req_we) begin
                mmem[int'((req_addr - 32'h4000) / 4)] =
                    merge(mmem_rd(int'((req_addr - 32'h4000) / 4)), req_wdata, req_be);
                m_valid = 1'b1;
            end else begin
                m_wait  = 1;
                m_rdata = in_rom(req_addr) ? rom_word(int'((req_addr - 32'h2000) / 4))
                                           : mmem_rd(int'((req_addr - 32'h4000) / 4));
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) m_valid = 1'b1;
        end else if (m_valid) begin
            if (rsp_ready) begin m_valid = 1'b0; m_ready = 1'b1; end
        end else if (!m_ready) begin
            m_ready = 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit acc, er, e_ram, e_rom;
        chk("req_ready", req_ready, m_ready);
        chk("rsp_valid", rsp_valid, m_valid);
        chk("err_count", err_count, 32'(m_cnt));
        if (m_valid) begin
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_err", rsp_err, m_err);
        end
        acc   = m_ready && req_valid && rst_n;
        er    = spec_err(req_we, req_addr, req_be);
        e_ram = acc && !er && in_ram(req_addr);
        e_rom = acc && !er && in_rom(req_addr);
        chk("ram_en", ram_en, e_ram);
        chk("ram_we", ram_we, e_ram && req_we);
        chk("rom_en", rom_en, e_rom);
        if (e_ram) begin
            chk("ram_addr", ram_addr, (req_addr - 32'h4000) / 4);
            chk("ram_wdata", ram_wdata, req_wdata);
            chk("ram_be", ram_be, req_be);
        end
        if (e_rom) chk("rom_addr", rom_addr, (req_addr - 32'h2000) / 4);
    end

    // ---------------- driver tasks ----------------
    logic [31:0] t_rd;
    logic        t_er, t_ram_en, t_rom_en;
    logic [10:0] t_ram_addr, t_rom_addr;
    int          t_lat;

    task automatic start_req(bit we, logic [31:0] a, logic [31:0] d, logic [3:0] be);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    endtask

    task automatic finish_req();
        bit ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (req_ready) begin
                t_ram_en = ram_en; t_ram_addr = ram_addr;
                t_rom_en = rom_en; t_rom_addr = rom_addr;
                @(posedge clk); #1;
                req_valid = 1'b0;
                ok = 1'b1;
                break;
            end
        end
        chk("accept_within_bound", ok, 1);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        bit ok = 1'b0;
        t_lat = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            t_lat++;
            if (rsp_valid) begin
                t_rd = rsp_rdata; t_er = rsp_err; ok = 1'b1;
                break;
            end
        end
        chk("rsp_within_bound", ok, 1);
    endtask

    task automatic txn(bit we, logic [31:0] a, logic [31:0] d, logic [3:0] be);
        start_req(we, a, d, be);
        finish_req();
        wait_rsp();
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] fa [4];
        bit          fw [4];
        logic [3:0]  fb [4];
        logic [31:0] bnd [6];

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_req_ready_low", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_err_count", err_count, 0);
        @(negedge clk);
        chk("req_ready_after_release", req_ready, 1);

        // store then load at 0x4004
        txn(1'b1, 32'h4004, 32'hDEAD_BEEF, 4'hF);
        chk("st_ram_en", t_ram_en, 1);
        chk("st_ram_addr", t_ram_addr, 11'd1);
        chk("st_latency", t_lat, 1);
        chk("st_err", t_er, 0);
        chk("st_rdata", t_rd, 0);
        txn(1'b0, 32'h4004, 32'h0, 4'h0);
        chk("ld_ram_addr", t_ram_addr, 11'd1);
        chk("ld_latency", t_lat, 2);
        chk("ld_rdata", t_rd, 32'hDEAD_BEEF);
        chk("ld_err", t_er, 0);

        // window boundaries
        txn(1'b0, 32'h5FFC, 32'h0, 4'hF);
        chk("ram_top_addr", t_ram_addr, 11'h7FF);
        chk("ram_top_rdata", t_rd, 32'hA5A5_07FF);
        txn(1'b0, 32'h6000, 32'h0, 4'hF);
        chk("ram_end_err", t_er, 1);
        chk("ram_end_latency", t_lat, 1);
        chk("ram_end_no_strobe", t_ram_en, 0);
        chk("ram_end_err_count", err_count, 1);
        txn(1'b0, 32'h2000, 32'h0, 4'hF);
        chk("rom_base_en", t_rom_en, 1);
        chk("rom_base_addr", t_rom_addr, 11'h000);
        chk("rom_base_rdata", t_rd, 32'h1234_0000);
        txn(1'b0, 32'h3FFC, 32'h0, 4'hF);
        chk("rom_top_addr", t_rom_addr, 11'h7FF);
        chk("rom_top_rdata", t_rd, 32'h1234_07FF);

        // access faults
        do_reset();
        fa = '{32'h2010, 32'h4002, 32'h0, 32'h4008};
        fw = '{1'b1, 1'b0, 1'b0, 1'b1};
        fb = '{4'hF, 4'hF, 4'hF, 4'h0};
        for (int i = 0; i < 4; i++) begin
            txn(fw[i], fa[i], 32'h5555_AAAA, fb[i]);
            chk("fault_err", t_er, 1);
            chk("fault_rdata", t_rd, 0);
        end
        chk("fault_err_count", err_count, 4);

        // backpressure with a competing request
        rdy_force = 1'b0;
        start_req(1'b0, 32'h4004, 32'h0, 4'hF);
        finish_req();
        wait_rsp();
        start_req(1'b1, 32'h4010, 32'h1111_2222, 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rdata", rsp_rdata, 32'hDEAD_BEEF);
            chk("bp_req_ready", req_ready, 0);
        end
        @(posedge clk); #1; rdy_force = 1'b1;
        finish_req();
        wait_rsp();
        chk("bp_second_err", t_er, 0);

        // reset while waiting on a load
        start_req(1'b0, 32'h4004, 32'h0, 4'hF);
        finish_req();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_rdwait_rsp_valid", rsp_valid, 0);
        chk("rst_rdwait_req_ready", req_ready, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready_low", req_ready, 0);
        @(negedge clk);
        chk("rst_release_ready_high", req_ready, 1);
        txn(1'b0, 32'h4004, 32'h0, 4'hF);
        chk("post_rst_rdata", t_rd, 32'hDEAD_BEEF);
        chk("post_rst_latency", t_lat, 2);

        // randomized traffic with random response backpressure
        bnd = '{32'h1FFC, 32'h2000, 32'h3FFC, 32'h4000, 32'h5FFC, 32'h6000};
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 7))
                0: a = 32'h4000 + 4 * $urandom_range(0, 2047);
                1: a = 32'h2000 + 4 * $urandom_range(0, 2047);
                2: a = bnd[$urandom_range(0, 5)];
                3: a = 32'h4000 + 4 * $urandom_range(0, 100) + $urandom_range(1, 3);
                4: a = $urandom;
                default: a = 32'h4000 + 4 * $urandom_range(0, 15);
            endcase
            start_req(1'($urandom_range(0, 1)), a, $urandom,
                      ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15)));
            finish_req();
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        rand_rdy = 1'b0;
        repeat (5) @(posedge clk);

        // error-count saturation
        for (int i = 0; i < 300; i++) begin
            txn(1'b0, 32'h8000_0000 + 32'(4 * i), 32'h0, 4'hF);
        end
        @(negedge clk);
        chk("err_count_saturated", err_count, 8'hFF);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_bus_responder.md
# data_bus_responder

Responder end of the CPU data-memory bus. Accepts one load/store request at a time from the core and decodes it against the system memory map. RAM-window accesses go to the synchronous data RAM; loads in the ROM window go to the instruction ROM's second read port. Returns a response with read data or an error flag, and sits between the core's load/store unit and the memory macros.

## Interface
Parameters:
- DATA_RAM_BEGIN, 32'h0000_4000, first byte address of data RAM window
- DATA_RAM_END, 32'h0000_6000, first byte address past data RAM window
- INST_ROM_BEGIN, 32'h0000_2000, first byte address of instruction ROM window
- INST_ROM_END, 32'h0000_4000, first byte address past instruction ROM window
- WORD_WIDTH, 32, data word width
- ADDR_WIDTH, 11, RAM word-index width, clog2((DATA_RAM_END-DATA_RAM_BEGIN)/4)
- ROM_ADDR_WIDTH, 11, ROM word-index width

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  WORD_WIDTH  store data
- req_be  in  4  byte enables, store only
- rsp_valid  out  1  response present
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  WORD_WIDTH  load data, 0 on store or error
- rsp_err  out  1  access fault
- ram_en, ram_we  out  1  RAM port strobes
- ram_addr  out  ADDR_WIDTH  RAM word index
- ram_wdata  out  WORD_WIDTH; ram_be  out  4
- ram_rdata  in  WORD_WIDTH  RAM data, valid 1 cycle after ram_en
- rom_en  out  1; rom_addr  out  ROM_ADDR_WIDTH; rom_rdata  in  WORD_WIDTH  1-cycle latency
- err_count  out  8  saturating count of error responses

## Operation
- States: IDLE, RD_WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, decode req_addr:
  - RAM hit: DATA_RAM_BEGIN <= addr < DATA_RAM_END.
  - ROM hit: INST_ROM_BEGIN <= addr < INST_ROM_END.
  - Error: addr[1:0]!=0, or unmapped address, or store to ROM, or store with req_be==0. Ends are exclusive.
- RAM index = (addr-DATA_RAM_BEGIN)>>2, truncated to ADDR_WIDTH. ROM index = (addr-INST_ROM_BEGIN)>>2.
- Store hit: ram_en=ram_we=1 combinationally in the accept cycle with wdata and be passed through. Next state is RESP with rdata=0, err=0.
- Load hit: ram_en or rom_en=1, we=0, in the accept cycle. Next state is RD_WAIT, which captures ram_rdata or rom_rdata into the rsp_rdata register. Then RESP.
- Error: no memory strobe. Next state is RESP with err=1, rdata=0. err_count increments and saturates at 8'hFF.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready, then return to IDLE. req_ready=0 in RD_WAIT and RESP.
- Memory strobes are never asserted outside an IDLE accept cycle.

## Timing
- Reset (rst_n=0 at an edge): state IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, err_count=0. req_ready is registered: it is 0 while in reset and 1 on the first cycle after release.
- Reset mid-operation aborts the transaction. No response is produced. Any RAM write strobe already issued in the accept cycle stands.
- Latency from accept edge T: store or error gives rsp_valid at T+1; load gives rsp_valid at T+2.
- rsp_ready held high: accept-to-accept is 2 cycles for store or error, 3 for load. There is no same-cycle rsp/req overlap.
- rsp_ready low: RESP is held indefinitely with data stable.
- req_valid during busy states is ignored, not queued.

## Test plan
- Store 0xDEADBEEF to 0x4004, be=4'hF, then load 0x4004: ram_addr=1 on both; store rsp at T+1 with err=0; load rsp at T+2 with rdata=0xDEADBEEF, err=0.
- Boundaries: load 0x5FFC hits ram_addr=0x7FF. Load 0x6000 gives err=1 at T+1, no ram_en, err_count=1. Load 0x2000 gives rom_en with rom_addr=0. Load 0x3FFC gives rom_addr=0x7FF.
- Faults: store to 0x2010, load from 0x4002, load from 0x0000_0000, and store with be=0 each return err=1 and rdata=0; err_count reaches 4.
- Backpressure: rsp_ready=0 for 5 cycles after a load completes. rsp_valid and rdata stay stable, req_ready=0, and a second req_valid is not accepted until the cycle after the rsp handshake.
- Reset asserted in RD_WAIT: next cycle state is IDLE, rsp_valid=0, req_ready=0. After release, req_ready=1 one cycle later and a fresh load completes normally.
- 300 consecutive error accesses: err_count saturates at 255.
